jk_seq_driver: RTL and testbench

Sequence driver for an external JK flip-flop (async-reset, posedge-triggered, Q/Qbar outputs). It accepts a WIDTH-bit target pattern and, one bit per clock, drives J/K so that the flip-flop's Q follows the pattern. Drive values come from the JK excitation table applied to the live Q feedback. It checks every resulting Q against the target and reports the first mismatch. It sits on the initiator side of the J/K interface, in front of flip-flop instances under test or in counter/register datapaths.

---
 rtl/jk_seq_driver_if.sv | 25 ++
 rtl/jk_seq_driver.sv | 103 ++++++++++
 tb/tb_jk_seq_driver.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_seq_driver_if.sv
// Request/response and J/K drive signals between a requester and jk_seq_driver.
interface jk_seq_driver_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = 3
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic             q_fb;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDXW-1:0]  err_index;

    modport master (
        output start, pattern, q_fb,
        input  j, k, busy, done, error, err_index
    );

    modport slave (
        input  start, pattern, q_fb,
        output j, k, busy, done, error, err_index
    );
endinterface

// File: rtl/jk_seq_driver.sv
// Drives an external JK flip-flop through a WIDTH-bit target sequence and
// records the index of the first bit whose Q feedback missed its target.
module jk_seq_driver #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned IDXW       = 3,
    parameter bit          USE_TOGGLE = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    jk_seq_driver_if.slave bus
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] pat_q;
    logic [IDXW-1:0]  idx_q;
    logic [IDXW-1:0]  err_index_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic             tgt;
    logic [IDXW-1:0]  chk_idx;
    logic             chk_en;
    logic             mismatch;
    logic             drv_j;
    logic             drv_k;

    // Q for bit i is visible one cycle after it is driven, so DRIVE checks the
    // previous bit; CHECK keeps idx at the last bit and checks it directly.
    always_comb begin
        tgt      = pat_q[idx_q];
        chk_idx  = (state_q == CHECK) ? idx_q : idx_q - IDXW'(1);
        chk_en   = (state_q == CHECK) || ((state_q == DRIVE) && (idx_q != '0));
        mismatch = chk_en && (bus.q_fb != pat_q[chk_idx]);
        drv_j    = 1'b0;
        drv_k    = 1'b0;
        if (state_q == DRIVE) begin
            case ({bus.q_fb, tgt})
                2'b01:   begin drv_j = 1'b1;       drv_k = USE_TOGGLE; end
                2'b10:   begin drv_j = USE_TOGGLE; drv_k = 1'b1;       end
                default: begin drv_j = 1'b0;       drv_k = 1'b0;       end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (mismatch && !error_q) begin
                error_q     <= 1'b1;
                err_index_q <= chk_idx;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        pat_q       <= bus.pattern;
                        idx_q       <= '0;
                        error_q     <= 1'b0;
                        err_index_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= CHECK;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                CHECK: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.j         = drv_j;
    assign bus.k         = drv_k;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.err_index = err_index_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Scoreboard bench for jk_seq_driver: toggle and set/reset variants, each driving
// its own JK flip-flop model with selectable faults.
module tb_jk_seq_driver;

    localparam int W  = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [2*W-1:0] jk;
        logic           err;
        logic [IW-1:0]  idx;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] pattern = '0;
    int           fault_mode = 0;

    logic q_t, q_s;
    int   bit_t, bit_s;

    int n_cmp = 0;
    int n_fail = 0;

    exp_t           sb_t[$];
    exp_t           sb_s[$];
    logic           rq[2];
    logic [2*W-1:0] jk_log[2];
    int             cyc[2];

    jk_seq_driver_if #(.WIDTH(W), .IDXW(IW)) bus_t ();
    jk_seq_driver_if #(.WIDTH(W), .IDXW(IW)) bus_s ();

    assign bus_t.start   = start;
    assign bus_t.pattern = pattern;
    assign bus_t.q_fb    = q_t;
    assign bus_s.start   = start;
    assign bus_s.pattern = pattern;
    assign bus_s.q_fb    = q_s;

    jk_seq_driver #(.WIDTH(W), .IDXW(IW), .USE_TOGGLE(1'b1)) u_dut_t (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_t)
    );

    jk_seq_driver #(.WIDTH(W), .IDXW(IW), .USE_TOGGLE(1'b0)) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    always #5 clk = ~clk;

    // Flip-flop under test; mode 1 = Q stuck at 0, mode 2 = J ignored from bit 4.
    function automatic logic ff_next(input logic q, input logic j, input logic k, input int b);
        logic jj;
        if (fault_mode == 1) return 1'b0;
        jj = (fault_mode == 2 && b >= 4) ? 1'b0 : j;
        case ({jj, k})
            2'b00:   return q;
            2'b10:   return 1'b1;
            2'b01:   return 1'b0;
            default: return ~q;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q_t   <= 1'b0;
            bit_t <= 0;
        end else begin
            q_t   <= ff_next(q_t, bus_t.j, bus_t.k, bit_t);
            bit_t <= bus_t.busy ? bit_t + 1 : 0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q_s   <= 1'b0;
            bit_s <= 0;
        end else begin
            q_s   <= ff_next(q_s, bus_s.j, bus_s.k, bit_s);
            bit_s <= bus_s.busy ? bit_s + 1 : 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: a good flip-flop lands on the target; stuck lands on 0; with J
    // ignored Q can only fall, so it lands on q & t. Drive is needed only on change.
    task automatic push_ref(input logic [W-1:0] pat);
        exp_t e;
        logic q, t, qn;
        for (int n = 0; n < 2; n++) begin
            q = rq[n];
            e = '0;
            for (int i = 0; i < W; i++) begin
                t = pat[i];
                if (q != t) e.jk[2*i +: 2] = (n == 0) ? 2'b11 : (t ? 2'b10 : 2'b01);
                case (fault_mode)
                    1:       qn = 1'b0;
                    2:       qn = (i >= 4) ? (q & t) : t;
                    default: qn = t;
                endcase
                if (qn != t && !e.err) begin
                    e.err = 1'b1;
                    e.idx = IW'(i);
                end
                q = qn;
            end
            rq[n] = q;
            if (n == 0) sb_t.push_back(e);
            else        sb_s.push_back(e);
        end
    endtask

    task automatic mon_inst(input int n, input logic busy, input logic done, input logic j,
                            input logic k, input logic err, input logic [IW-1:0] ei);
        exp_t  e;
        string tag;
        logic  have;
        tag = (n == 0) ? "tog" : "sr";
        if (busy) begin
            if (cyc[n] < W) jk_log[n][2*cyc[n] +: 2] = {j, k};
            else            chk({tag, "_jk_after_drive"}, 32'({j, k}), 32'(0));
            cyc[n]++;
        end else begin
            cyc[n] = 0;
        end
        if (done) begin
            have = (n == 0) ? (sb_t.size() != 0) : (sb_s.size() != 0);
            if (!have) begin
                chk({tag, "_done_unexpected"}, 32'(1), 32'(0));
            end else begin
                e = (n == 0) ? sb_t.pop_front() : sb_s.pop_front();
                chk({tag, "_jk_seq"}, 32'(jk_log[n]), 32'(e.jk));
                chk({tag, "_error"}, 32'(err), 32'(e.err));
                chk({tag, "_err_index"}, 32'(ei), 32'(e.idx));
                chk({tag, "_done_cycle"}, 32'(cyc[n]), 32'(W + 2));
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc[0] = 0;
                cyc[1] = 0;
            end else begin
                mon_inst(0, bus_t.busy, bus_t.done, bus_t.j, bus_t.k, bus_t.error, bus_t.err_index);
                mon_inst(1, bus_s.busy, bus_s.done, bus_s.j, bus_s.k, bus_s.error, bus_s.err_index);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tog_jk"},   32'({bus_t.j, bus_t.k}), 32'(0));
        chk({tag, "_tog_busy"}, 32'(bus_t.busy), 32'(0));
        chk({tag, "_tog_done"}, 32'(bus_t.done), 32'(0));
        chk({tag, "_tog_err"},  32'({bus_t.error, bus_t.err_index}), 32'(0));
        chk({tag, "_sr_jk"},    32'({bus_s.j, bus_s.k}), 32'(0));
        chk({tag, "_sr_busy"},  32'(bus_s.busy), 32'(0));
        chk({tag, "_sr_done"},  32'(bus_s.done), 32'(0));
        chk({tag, "_sr_err"},   32'({bus_s.error, bus_s.err_index}), 32'(0));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus_t.busy || bus_s.busy) && n < 4 * W) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus_t.busy || bus_s.busy) chk("idle_timeout", 32'(1), 32'(0));
    endtask

    task automatic run(input logic [W-1:0] pat, input int m);
        fault_mode = m;
        @(posedge clk);
        #1;
        if (m == 1) begin
            rq[0] = 1'b0;
            rq[1] = 1'b0;
        end
        start   = 1'b1;
        pattern = pat;
        push_ref(pat);
        @(posedge clk);
        #1;
        start   = 1'b0;
        pattern = W'($urandom);
        wait_idle();
    endtask

    initial begin
        logic [W-1:0] p;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        cyc[0] = 0;
        cyc[1] = 0;
        fork
            monitor();
        join_none

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        run(8'b10110010, 0);
        run(8'h0F, 1);
        run(8'hF0, 2);
        for (int r = 0; r < 24; r++) run(W'($urandom), int'($urandom_range(0, 2)));

        // Abort mid-sequence at idx=3 after an error has already been latched.
        fault_mode = 1;
        @(posedge clk);
        #1;
        start   = 1'b1;
        pattern = 8'h0F;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_abort_busy", 32'(bus_t.busy), 32'(1));
        chk("pre_abort_error", 32'(bus_t.error), 32'(1));
        reset = 1'b1;
        #1;
        chk_zero("abort");
        reset = 1'b0;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        run(8'b10110010, 0);

        // start held high: pattern churns during busy, second run takes the value
        // present when the driver is back in IDLE.
        fault_mode = 0;
        @(posedge clk);
        #1;
        p       = W'($urandom);
        start   = 1'b1;
        pattern = p;
        push_ref(p);
        for (int c = 0; c < W; c++) begin
            @(posedge clk);
            #1;
            pattern = W'($urandom);
        end
        @(posedge clk);
        #1;
        p       = W'($urandom);
        pattern = p;
        push_ref(p);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_tog_empty", 32'(sb_t.size()), 32'(0));
        chk("sb_sr_empty", 32'(sb_s.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
